// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: MDU op request (start/op/rs_val/rt_val) and status/result (busy/done/hi/lo) bundle
interface mdu_hilo_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master(output start, op, rs_val, rt_val, input busy, done, hi, lo);
  modport slave(input start, op, rs_val, rt_val, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: fixed-latency MULT/MULTU/DIV/DIVU with HI/LO regs, one-cycle MTHI/MTLO; ports clk, reset (async, active-high), bus (slave: start/op/rs_val/rt_val in, busy/done/hi/lo out); define MDU_DIV_EN to build the divider
module mdu_hilo #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_hilo_if.slave bus
);
  localparam int CW = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_lat;
  logic [31:0] r_a, r_b, r_hi, r_lo, w_hi, w_lo;
  logic r_sgn, r_done, w_op_ok, w_accept, w_fin, w_wr, w_mthi, w_mtlo;
  logic [63:0] w_prod;
  // one 64x64 multiplier covers both flavours: sign-extending only for MULT
  assign w_prod = {{32{r_sgn & r_a[31]}}, r_a} * {{32{r_sgn & r_b[31]}}, r_b};
`ifdef MDU_DIV_EN
  logic r_div, w_sa, w_sb;
  logic [31:0] w_ua, w_ub, w_ubz, w_uq, w_ur;
  assign w_op_ok = ~bus.op[2];
  assign w_lat = bus.op[1] ? CW'(DIV_LAT) : CW'(MULT_LAT);
  assign w_sa = r_sgn & r_a[31];
  assign w_sb = r_sgn & r_b[31];
  assign w_ua = w_sa ? -r_a : r_a;
  assign w_ub = w_sb ? -r_b : r_b;
  // a zero divisor never commits; forcing it to 1 keeps the divider output defined
  assign w_ubz = w_ub | {31'd0, r_b == '0};
  assign w_uq = w_ua / w_ubz;
  assign w_ur = w_ua % w_ubz;
  assign w_wr = w_fin & ~(r_div & (r_b == '0));
  assign {w_hi, w_lo} = r_div ? {w_sa ? -w_ur : w_ur, (w_sa ^ w_sb) ? -w_uq : w_uq} : w_prod;
`else
  assign w_op_ok = bus.op[2:1] == 2'b00;
  assign w_lat = CW'(MULT_LAT);
  assign w_wr = w_fin;
  assign {w_hi, w_lo} = w_prod;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = (r_state == IDLE) ? (w_accept ? RUN : IDLE) : (w_fin ? IDLE : RUN);
  always_comb begin
    w_accept = bus.start & (r_state == IDLE) & w_op_ok;
    w_fin = (r_state == RUN) & (r_cnt == CW'(1));
    w_mthi = bus.start & (r_state == IDLE) & (bus.op == 3'd4);
    w_mtlo = bus.start & (r_state == IDLE) & (bus.op == 3'd5);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_sgn <= 1'b0;
      r_hi <= '0;
      r_lo <= '0;
      r_done <= 1'b0;
`ifdef MDU_DIV_EN
      r_div <= 1'b0;
`endif
    end else begin
      r_done <= w_fin;
      r_cnt <= w_accept ? w_lat : r_cnt - CW'(r_state == RUN);
      if (w_accept) begin
        r_a <= bus.rs_val;
        r_b <= bus.rt_val;
        r_sgn <= ~bus.op[0];
`ifdef MDU_DIV_EN
        r_div <= bus.op[1];
`endif
      end
      r_hi <= w_wr ? w_hi : w_mthi ? bus.rs_val : r_hi;
      r_lo <= w_wr ? w_lo : w_mtlo ? bus.rs_val : r_lo;
    end
  assign bus.busy = r_state == RUN;
  assign bus.done = r_done;
  assign bus.hi = r_hi;
  assign bus.lo = r_lo;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized and directed checks of mdu_hilo against a behavioural HI/LO model
module tb_mdu_hilo;
  localparam int ML = 5;
  localparam int DL = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  mdu_hilo_if bus();
  mdu_hilo #(.MULT_LAT(ML), .DIV_LAT(DL)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_err = 0;
  bit run = 1'b0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  logic m_busy, m_done, m_keep;
  int m_rem;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (op == 3'd0) return longint'($signed(a)) * longint'($signed(b));
    if (op == 3'd1) return {32'd0, a} * {32'd0, b};
    if (op == 3'd2) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_hi <= '0;
      m_lo <= '0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_rem <= 0;
      m_keep <= 1'b0;
      m_res <= '0;
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      m_done <= m_rem == 1;
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        if (!m_keep) begin
          m_hi <= m_res[63:32];
          m_lo <= m_res[31:0];
        end
      end
    end else begin
      m_done <= 1'b0;
      if (bus.start && (bus.op < 3'd2 || (DIV_EN && bus.op < 3'd4))) begin
        m_busy <= 1'b1;
        m_rem <= bus.op < 3'd2 ? ML : DL;
        m_keep <= bus.op >= 3'd2 && bus.rt_val == '0;
        m_res <= (bus.op >= 3'd2 && bus.rt_val == '0) ? 64'd0 : ref_res(bus.op, bus.rs_val, bus.rt_val);
      end else if (bus.start && bus.op == 3'd4) m_hi <= bus.rs_val;
      else if (bus.start && bus.op == 3'd5) m_lo <= bus.rs_val;
    end
  always @(negedge clk)
    if (run) begin
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("hi", bus.hi, m_hi);
      chk("lo", bus.lo, m_lo);
    end
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise,
                        output int bc, output int dc);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op = op;
    bus.rs_val = a;
    bus.rt_val = b;
    bc = 0;
    dc = 0;
    for (int k = 0; k < DL + 6; k++) begin
      @(posedge clk);
      #2;
      bc += int'(bus.busy);
      dc += int'(bus.done);
      if (noise && k < 4) begin
        bus.start = 1'b1;
        bus.op = (k == 0) ? 3'd5 : 3'd3;
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
      end else bus.start = 1'b0;
    end
  endtask
  initial begin
    int bc, dc, sel;
    bus.start = 1'b0;
    bus.op = '0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    run = 1'b1;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.op = 3'd4;
    bus.rs_val = 32'h1234_5678;
    @(posedge clk);
    #1 bus.op = 3'd5;
    bus.rs_val = 32'h9ABC_DEF0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    #1;
    chk("mthi", bus.hi, 32'h1234_5678);
    chk("mtlo", bus.lo, 32'h9ABC_DEF0);
    chk("mt_busy", 32'(bus.busy), 32'd0);
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, bc, dc);
    chk("mult_busy_cyc", 32'(bc), 32'd5);
    chk("mult_done_cnt", 32'(dc), 32'd1);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, bc, dc);
    chk("multu_hi", bus.hi, 32'h0000_0002);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFA);
`ifdef MDU_DIV_EN
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, bc, dc);
    chk("div_busy_cyc", 32'(bc), 32'd10);
    chk("div_hi", bus.hi, 32'hFFFF_FFFF);
    chk("div_lo", bus.lo, 32'hFFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd0, 1'b0, bc, dc);
    chk("divz_busy_cyc", 32'(bc), 32'd10);
    chk("divz_done_cnt", 32'(dc), 32'd1);
    chk("divz_hi", bus.hi, 32'hFFFF_FFFF);
    chk("divz_lo", bus.lo, 32'hFFFF_FFFD);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc, dc);
    chk("divovf_hi", bus.hi, 32'h0000_0000);
    chk("divovf_lo", bus.lo, 32'h8000_0000);
`else
    run_op(3'd2, 32'd10, 32'd2, 1'b0, bc, dc);
    chk("nodiv_busy_cyc", 32'(bc), 32'd0);
    chk("nodiv_done_cnt", 32'(dc), 32'd0);
    chk("nodiv_hi", bus.hi, 32'h0000_0002);
    chk("nodiv_lo", bus.lo, 32'hFFFF_FFFA);
`endif
    run_op(3'd0, 32'h0001_0000, 32'h0001_0000, 1'b1, bc, dc);
    chk("noise_busy_cyc", 32'(bc), 32'd5);
    chk("noise_hi", bus.hi, 32'h0000_0001);
    chk("noise_lo", bus.lo, 32'h0000_0000);
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.op = 3'd0;
    bus.rs_val = 32'hFFFF_FFFE;
    bus.rt_val = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_hi", bus.hi, 32'd0);
    chk("midrst_lo", bus.lo, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    dc = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #2 dc += int'(bus.done);
    end
    chk("post_rst_done", 32'(dc), 32'd0);
    repeat (600) begin
      @(posedge clk);
      #1;
      bus.start = $urandom_range(0, 2) != 0;
      bus.op = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      bus.rs_val = (sel == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 7);
      bus.rt_val = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : (sel < 4) ? 32'($urandom_range(1, 100)) : $urandom;
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
